// File: rtl/pipeline_pkg.sv
// Shared definitions for the 8-bit pipeline front end: widths, opcodes, fetch FSM states.
package pipeline_pkg;

  localparam int DEF_IW = 8;
  localparam int DEF_AW = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_HALT = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // The opcode lives in the top two bits of every instruction word.
  function automatic logic isHalt(input logic [1:0] op);
    return opcode_t'(op) == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load, control and decode-side handshake signals of the instruction fetch unit.
interface instr_fetch_unit_if #(
  parameter int IW = pipeline_pkg::DEF_IW,
  parameter int AW = pipeline_pkg::DEF_AW
);

  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          start;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          busy;
  logic          halted;

  // Program loader / decode stage side.
  modport master (
    output load_valid, load_data, load_last, start, redirect_valid, redirect_pc, out_ready,
    input  load_ready, out_valid, out_instr, out_pc, busy, halted
  );

  // Fetch unit side.
  modport slave (
    input  load_valid, load_data, load_last, start, redirect_valid, redirect_pc, out_ready,
    output load_ready, out_valid, out_instr, out_pc, busy, halted
  );

endinterface

// File: rtl/fetch_imem.sv
// Instruction memory: synchronous write from the loader, asynchronous read for fetch.
module fetch_imem
  import pipeline_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem [2**AW];

  // Program words are written one beat per clock; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: loads the program into fetch_imem and streams instructions to decode.
module instr_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int AW = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_unit_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] loadPtr_q, loadPtr_d;
  logic          outValid_q, outValid_d;
  logic [IW-1:0] outInstr_q, outInstr_d;
  logic [AW-1:0] outPc_q, outPc_d;
  logic          halted_q, halted_d;

  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [IW-1:0] memRdata;
  logic          loadReady;
  logic          beat;
  logic          slotFree;

  fetch_imem #(.IW(IW), .AW(AW)) uImem (
    .clk     (clk),
    .we_i    (memWe),
    .waddr_i (memWaddr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_q),
    .rdata_o (memRdata)
  );

  assign loadReady = (state_q != S_RUN);
  assign beat      = bus.load_valid & loadReady;
  assign slotFree  = !outValid_q || bus.out_ready;

  // Next-state logic: load sequencing, start, fetch/stall, redirect and halt detection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loadPtr_d  = loadPtr_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outPc_d    = outPc_q;
    halted_d   = halted_q;
    memWe      = 1'b0;
    memWaddr   = loadPtr_q;

    if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (beat) begin
          memWe    = 1'b1;
          memWaddr = '0;
          halted_d = 1'b0;
          if (bus.load_last) begin
            state_d   = S_IDLE;
            loadPtr_d = '0;
          end else begin
            state_d   = S_LOAD;
            loadPtr_d = AW'(1);
          end
        end else if (bus.start) begin
          state_d  = S_RUN;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (beat) begin
          memWe    = 1'b1;
          memWaddr = loadPtr_q;
          if (bus.load_last || (loadPtr_q == LAST_ADDR)) begin
            state_d   = S_IDLE;
            loadPtr_d = '0;
          end else begin
            loadPtr_d = loadPtr_q + AW'(1);
          end
        end
      end
      S_RUN: begin
        if (bus.redirect_valid) begin
          outValid_d = 1'b0;
          pc_d       = bus.redirect_pc;
        end else if (slotFree) begin
          outValid_d = 1'b1;
          outInstr_d = memRdata;
          outPc_d    = pc_q;
          pc_d       = pc_q + AW'(1);
          if (isHalt(memRdata[IW-1 -: 2])) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC, load pointer and output register update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      loadPtr_q  <= '0;
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outPc_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loadPtr_q  <= loadPtr_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outPc_q    <= outPc_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.load_ready = loadReady;
  assign bus.out_valid  = outValid_q;
  assign bus.out_instr  = outInstr_q;
  assign bus.out_pc     = outPc_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed load/run/stall/redirect/reset scenarios.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [7:0] data, input logic last,
                               input logic st, input logic rv, input logic [3:0] rpc);
    bus.load_valid     = lv;
    bus.load_data      = data;
    bus.load_last      = last;
    bus.start          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic pushExp(input logic [3:0] pc, input logic [7:0] instr);
    expQ.push_back({pc, instr});
  endtask

  task automatic loadWord(input logic [7:0] data, input logic last);
    applyStimulus(1'b1, data, last, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d outputs pending expected 0 within %0d cycles", name, expQ.size(), maxCycles);
      expQ.delete();
    end
  endtask

  // Monitor: every accepted output is compared against the head of the scoreboard queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got pc=%0d instr=0x%0h expected none", bus.out_pc, bus.out_instr);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_pc", 32'(bus.out_pc), 32'(e.pc));
        checkOutput("out_instr", 32'(bus.out_instr), 32'(e.instr));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_instr", 32'(bus.out_instr), 32'd0);
    checkOutput("rst_out_pc", 32'(bus.out_pc), 32'd0);
    checkOutput("rst_halted", 32'(bus.halted), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_load_ready", 32'(bus.load_ready), 32'd1);
    rst = 1'b0;

    $display("[TB] short program ending in HALT");
    loadWord(8'h16, 1'b0);
    checkOutput("load_busy", 32'(bus.busy), 32'd1);
    loadWord(8'h5B, 1'b0);
    loadWord(8'h24, 1'b0);
    loadWord(8'hC0, 1'b1);
    checkOutput("load_done_busy", 32'(bus.busy), 32'd0);
    pushExp(4'd0, 8'h16);
    pushExp(4'd1, 8'h5B);
    pushExp(4'd2, 8'h24);
    pushExp(4'd3, 8'hC0);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    checkOutput("latency_before", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_first", 32'(bus.out_valid), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("throughput_drained", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("halt_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("halt_halted", 32'(bus.halted), 32'd1);
    checkOutput("halt_busy", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b0;

    $display("[TB] full 16-word program, wrap-around");
    for (int i = 0; i < 16; i++) begin
      loadWord(8'h10 + 8'(i), 1'b0);
    end
    checkOutput("full_load_busy", 32'(bus.busy), 32'd0);
    checkOutput("full_load_halted", 32'(bus.halted), 32'd0);
    for (int i = 0; i < 16; i++) begin
      pushExp(4'(i), 8'h10 + 8'(i));
    end
    pushExp(4'd0, 8'h10);
    pushExp(4'd1, 8'h11);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    waitDrain("wrap_drain", 40);
    bus.out_ready = 1'b0;

    $display("[TB] downstream stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall_pc", 32'(bus.out_pc), 32'd2);
      checkOutput("stall_instr", 32'(bus.out_instr), 32'h12);
    end
    checkOutput("run_load_ready", 32'(bus.load_ready), 32'd0);
    @(posedge clk);
    #1;
    pushExp(4'd2, 8'h12);
    pushExp(4'd3, 8'h13);
    pushExp(4'd4, 8'h14);
    bus.out_ready = 1'b1;
    waitDrain("stall_release", 10);
    bus.out_ready = 1'b0;

    $display("[TB] redirect while stalled");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("redirect2_flush", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("redirect2_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("redirect2_pc", 32'(bus.out_pc), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd9);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("redirect9_flush", 32'(bus.out_valid), 32'd0);
    pushExp(4'd9, 8'h19);
    pushExp(4'd10, 8'h1A);
    bus.out_ready = 1'b1;
    waitDrain("redirect9_drain", 10);
    bus.out_ready = 1'b0;

    $display("[TB] reset during run");
    checkOutput("prereset_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_out_instr", 32'(bus.out_instr), 32'd0);
    checkOutput("midrst_out_pc", 32'(bus.out_pc), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushExp(4'd0, 8'h10);
    pushExp(4'd1, 8'h11);
    pushExp(4'd2, 8'h12);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    waitDrain("replay_drain", 10);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] same-cycle priorities");
    applyStimulus(1'b1, 8'h3F, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("load_vs_start_busy", 32'(bus.busy), 32'd1);
    checkOutput("load_vs_start_valid", 32'(bus.out_valid), 32'd0);
    loadWord(8'hC5, 1'b1);
    checkOutput("prio_load_done", 32'(bus.busy), 32'd0);
    pushExp(4'd0, 8'h3F);
    pushExp(4'd4, 8'h14);
    pushExp(4'd5, 8'h15);
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("redirect_halt_flush", 32'(bus.out_valid), 32'd0);
    waitDrain("redirect_halt_drain", 10);
    checkOutput("redirect_no_halt", 32'(bus.halted), 32'd0);
    checkOutput("redirect_still_busy", 32'(bus.busy), 32'd1);
    bus.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
